// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched instruction word
// into the control bundle, registered once for execute/memory/writeback.

package controlsgs_pkg;
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [1:0]  alu_src_a;
        logic        alu_src_b;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        branch;
        logic [2:0]  branch_cond;
        logic        jump;
        logic        jalr;
        logic [1:0]  wb_sel;
        logic        illegal;
    } controlsgs_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;
endpackage

module decode_stage
    import controlsgs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output controlsgs_t controlsgs
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_MISC   = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // funct3 -> ALU op shared by OP and OP-IMM; funct7 overrides handled by caller
    function automatic logic [3:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'd0:    alu_base = ALU_ADD;
            3'd1:    alu_base = ALU_SLL;
            3'd2:    alu_base = ALU_SLT;
            3'd3:    alu_base = ALU_SLTU;
            3'd4:    alu_base = ALU_XOR;
            3'd5:    alu_base = ALU_SRL;
            3'd6:    alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

    controlsgs_t ctl_d, ctl_q;
    logic        ill;

    // Combinational decode; any illegal encoding collapses to a bare illegal flag
    always_comb begin
        ctl_d     = '0;
        ill       = 1'b0;
        ctl_d.rs1 = instr[19:15];
        ctl_d.rs2 = instr[24:20];
        ctl_d.rd  = instr[11:7];
        case (opcode)
            OPC_OP: begin
                ctl_d.reg_write = 1'b1;
                if (funct7 == 7'h00) begin
                    ctl_d.alu_op = alu_base(funct3);
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    ctl_d.alu_op = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    ctl_d.alu_op = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                ctl_d.imm       = imm_i;
                ctl_d.alu_src_b = 1'b1;
                ctl_d.reg_write = 1'b1;
                ctl_d.alu_op    = alu_base(funct3);
                // Shift-immediates reuse the upper immediate bits as funct7
                if (funct3 == 3'd1 && funct7 != 7'h00) ill = 1'b1;
                if (funct3 == 3'd5) begin
                    if (funct7 == 7'h20)      ctl_d.alu_op = ALU_SRA;
                    else if (funct7 != 7'h00) ill = 1'b1;
                end
            end
            OPC_LOAD: begin
                ctl_d.imm          = imm_i;
                ctl_d.alu_src_b    = 1'b1;
                ctl_d.mem_read     = 1'b1;
                ctl_d.reg_write    = 1'b1;
                ctl_d.wb_sel       = WB_MEM;
                ctl_d.mem_size     = funct3[1:0];
                ctl_d.mem_unsigned = funct3[2];
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) ill = 1'b1;
            end
            OPC_STORE: begin
                ctl_d.imm       = imm_s;
                ctl_d.alu_src_b = 1'b1;
                ctl_d.mem_write = 1'b1;
                ctl_d.mem_size  = funct3[1:0];
                if (funct3 > 3'd2) ill = 1'b1;
            end
            OPC_BRANCH: begin
                ctl_d.imm         = imm_b;
                ctl_d.alu_op      = ALU_SUB;
                ctl_d.branch      = 1'b1;
                ctl_d.branch_cond = funct3;
                if (funct3 == 3'd2 || funct3 == 3'd3) ill = 1'b1;
            end
            OPC_JAL: begin
                ctl_d.imm       = imm_j;
                ctl_d.alu_src_a = SRCA_PC;
                ctl_d.alu_src_b = 1'b1;
                ctl_d.jump      = 1'b1;
                ctl_d.reg_write = 1'b1;
                ctl_d.wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                ctl_d.imm       = imm_i;
                ctl_d.alu_src_b = 1'b1;
                ctl_d.jump      = 1'b1;
                ctl_d.jalr      = 1'b1;
                ctl_d.reg_write = 1'b1;
                ctl_d.wb_sel    = WB_PC4;
                if (funct3 != 3'd0) ill = 1'b1;
            end
            OPC_LUI: begin
                ctl_d.imm       = imm_u;
                ctl_d.alu_src_a = SRCA_ZERO;
                ctl_d.alu_src_b = 1'b1;
                ctl_d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                ctl_d.imm       = imm_u;
                ctl_d.alu_src_a = SRCA_PC;
                ctl_d.alu_src_b = 1'b1;
                ctl_d.reg_write = 1'b1;
            end
            OPC_MISC, OPC_SYSTEM: begin
                // Fences and system ops retire as NOPs in this core
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            ctl_d         = '0;
            ctl_d.illegal = 1'b1;
        end
    end

    // Output register; reset injects an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst) ctl_q <= '0;
        else     ctl_q <= ctl_d;
    end

    assign controlsgs = ctl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: per-cycle comparison against a behavioural decoder,
// plus literal field checks on hand-decoded instructions.

module tb_decode_stage;
    import controlsgs_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h00500093;
    controlsgs_t controlsgs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .controlsgs(controlsgs)
    );

    localparam logic [3:0] BASE_OP [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    // Decoder written from the instruction-set rules, field by field
    function automatic controlsgs_t model(input logic [31:0] w);
        controlsgs_t c;
        bit ok;
        int op, f3, f7;
        logic signed [31:0] sw;
        logic [31:0] ii, si, bi, ui, ji;
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        sw = w;
        ii = 32'(sw >>> 20);
        si = 32'((sw >>> 25) <<< 5) | 32'(w[11:7]);
        bi = (w[31] ? 32'hFFFFF000 : 32'h0) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        ui = w & 32'hFFFFF000;
        ji = (w[31] ? 32'hFFF00000 : 32'h0) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        c = '0;
        ok = 1'b1;
        c.rs1 = w[19:15];
        c.rs2 = w[24:20];
        c.rd  = w[11:7];
        case (op)
            'h33: begin
                ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
                c.alu_op = (f7 == 'h20) ? ((f3 == 0) ? 4'd1 : 4'd7) : BASE_OP[f3];
                c.reg_write = 1'b1;
            end
            'h13: begin
                ok = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 'h20);
                c.alu_op = (f3 == 5 && f7 == 'h20) ? 4'd7 : BASE_OP[f3];
                c.imm = ii; c.alu_src_b = 1'b1; c.reg_write = 1'b1;
            end
            'h03: begin
                ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                c.imm = ii; c.alu_src_b = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1;
                c.wb_sel = 2'd1;
                c.mem_size = 2'(f3 % 4);
                c.mem_unsigned = (f3 >= 4);
            end
            'h23: begin
                ok = (f3 <= 2);
                c.imm = si; c.alu_src_b = 1'b1; c.mem_write = 1'b1; c.mem_size = 2'(f3);
            end
            'h63: begin
                ok = !(f3 == 2 || f3 == 3);
                c.imm = bi; c.alu_op = 4'd1; c.branch = 1'b1; c.branch_cond = 3'(f3);
            end
            'h6F: begin
                c.imm = ji; c.alu_src_a = 2'd1; c.alu_src_b = 1'b1;
                c.jump = 1'b1; c.reg_write = 1'b1; c.wb_sel = 2'd2;
            end
            'h67: begin
                ok = (f3 == 0);
                c.imm = ii; c.alu_src_b = 1'b1; c.jump = 1'b1; c.jalr = 1'b1;
                c.reg_write = 1'b1; c.wb_sel = 2'd2;
            end
            'h37: begin c.imm = ui; c.alu_src_a = 2'd2; c.alu_src_b = 1'b1; c.reg_write = 1'b1; end
            'h17: begin c.imm = ui; c.alu_src_a = 2'd1; c.alu_src_b = 1'b1; c.reg_write = 1'b1; end
            'h0F, 'h73: ;
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            c = '0;
            c.illegal = 1'b1;
        end
        return c;
    endfunction

    // Expected bundle for the edge just taken
    controlsgs_t exp_b;
    bit          exp_vld = 1'b0;

    always @(posedge clk) begin
        exp_b   = rst ? controlsgs_t'('0) : model(instr);
        exp_vld = 1'b1;
    end

    // Every cycle: registered output must equal the model
    always @(negedge clk) begin
        if (exp_vld) begin
            checks++;
            if (controlsgs !== exp_b) begin
                errors++;
                $display("FAIL model bundle t=%0t got %h want %h", $time, controlsgs, exp_b);
            end
        end
    end

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] w);
        @(negedge clk);
        instr = w;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] SWEEP [20] = '{
        32'h4020D1B3, 32'h4030D093, 32'h0000C083, 32'h0000D083, 32'h00003083,
        32'h0000B023, 32'h00114463, 32'h00112463, 32'h000080E7, 32'h000090E7,
        32'h00001517, 32'h0FF0000F, 32'h00000073, 32'h0000007F, 32'h02009093,
        32'h00209093, 32'h0020F0B3, 32'h0020E0B3, 32'hFFF00093, 32'h8000A093
    };

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset bundle", 69'(controlsgs), 69'd0);

        @(negedge clk);
        rst = 1'b0;
        step(32'h00500093);
        chk("addi rd", 69'(controlsgs.rd), 69'd1);
        chk("addi rs1", 69'(controlsgs.rs1), 69'd0);
        chk("addi imm", 69'(controlsgs.imm), 69'd5);
        chk("addi alu_op", 69'(controlsgs.alu_op), 69'd0);
        chk("addi src_b", 69'(controlsgs.alu_src_b), 69'd1);
        chk("addi reg_write", 69'(controlsgs.reg_write), 69'd1);
        chk("addi wb_sel", 69'(controlsgs.wb_sel), 69'd0);

        step(32'h002081B3);
        chk("add alu_op", 69'(controlsgs.alu_op), 69'd0);
        chk("add src_b", 69'(controlsgs.alu_src_b), 69'd0);
        chk("add rd", 69'(controlsgs.rd), 69'd3);
        step(32'h402081B3);
        chk("sub alu_op", 69'(controlsgs.alu_op), 69'd1);
        step(32'h042080B3);
        chk("bad f7 illegal", 69'(controlsgs.illegal), 69'd1);
        chk("bad f7 reg_write", 69'(controlsgs.reg_write), 69'd0);
        chk("bad f7 rd cleared", 69'(controlsgs.rd), 69'd0);

        step(32'h00812283);
        chk("lw mem_read", 69'(controlsgs.mem_read), 69'd1);
        chk("lw mem_size", 69'(controlsgs.mem_size), 69'd2);
        chk("lw imm", 69'(controlsgs.imm), 69'd8);
        chk("lw wb_sel", 69'(controlsgs.wb_sel), 69'd1);
        step(32'h00512623);
        chk("sw mem_write", 69'(controlsgs.mem_write), 69'd1);
        chk("sw reg_write", 69'(controlsgs.reg_write), 69'd0);
        chk("sw imm", 69'(controlsgs.imm), 69'd12);
        chk("sw rs2", 69'(controlsgs.rs2), 69'd5);

        step(32'hFE208CE3);
        chk("beq branch", 69'(controlsgs.branch), 69'd1);
        chk("beq cond", 69'(controlsgs.branch_cond), 69'd0);
        chk("beq imm", 69'(controlsgs.imm), 69'(32'hFFFFFFF8));
        chk("beq alu_op", 69'(controlsgs.alu_op), 69'd1);

        step(32'h010000EF);
        chk("jal jump", 69'(controlsgs.jump), 69'd1);
        chk("jal imm", 69'(controlsgs.imm), 69'd16);
        chk("jal wb_sel", 69'(controlsgs.wb_sel), 69'd2);
        chk("jal rd", 69'(controlsgs.rd), 69'd1);
        step(32'h12345237);
        chk("lui imm", 69'(controlsgs.imm), 69'(32'h12345000));
        chk("lui src_a", 69'(controlsgs.alu_src_a), 69'd2);

        step(32'h0000C083);
        chk("lbu unsigned", 69'(controlsgs.mem_unsigned), 69'd1);
        chk("lbu size", 69'(controlsgs.mem_size), 69'd0);
        step(32'h4030D093);
        chk("srai alu_op", 69'(controlsgs.alu_op), 69'd7);
        step(32'h0FF0000F);
        chk("fence illegal", 69'(controlsgs.illegal), 69'd0);
        chk("fence reg_write", 69'(controlsgs.reg_write), 69'd0);

        for (int i = 0; i < 20; i++) step(SWEEP[i]);

        step(32'h00000000);
        chk("zero word illegal", 69'(controlsgs.illegal), 69'd1);
        @(negedge clk);
        rst   = 1'b1;
        instr = 32'h002081B3;
        @(posedge clk);
        #1;
        chk("mid-stream reset bundle", 69'(controlsgs), 69'd0);
        @(negedge clk);
        rst = 1'b0;
        step(32'h002081B3);
        chk("after reset add rd", 69'(controlsgs.rd), 69'd3);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
